// File: rtl/draw_arbiter.sv
// Pixel-port arbiter: grants one drawing source at a time, forwards its pixels
// to the VGA adapter with one cycle of latency, and generates the frame tick.
module draw_arbiter #(
  parameter int N_SRC      = 3,
  parameter int X_W        = 8,
  parameter int Y_W        = 8,
  parameter int COL_W      = 3,
  parameter int MODE       = 0,
  parameter int FRAME_DIV  = 833333,
  parameter int FRAME_SYNC = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC-1:0]       src_req,
  input  logic [N_SRC-1:0]       src_valid,
  input  logic [N_SRC-1:0]       src_last,
  input  logic [N_SRC*X_W-1:0]   src_x,
  input  logic [N_SRC*Y_W-1:0]   src_y,
  input  logic [N_SRC*COL_W-1:0] src_colour,
  output logic [N_SRC-1:0]       gnt,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [COL_W-1:0]       colour,
  output logic                   plot,
  output logic                   frame_tick,
  output logic                   busy
);

  // state | meaning
  // IDLE  | no owner; arbitrate when eligible
  // GRANT | gnt one-hot, grantee's pixels forwarded
  // GAP   | one dead cycle after a burst ends
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam int IDX_W = $clog2(N_SRC);
  localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FRAME_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_SRC - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   gnt_idx_q, rr_ptr_q, win;
  logic [CNT_W-1:0]   cnt_q;
  logic               pending_q;
  logic               eligible, g_plot, g_end;
  logic [N_SRC-1:0]   gnt_d;
  logic               plot_d;
  logic [X_W-1:0]     x_d;
  logic [Y_W-1:0]     y_d;
  logic [COL_W-1:0]   col_d;

  logic [X_W-1:0]   x_arr   [N_SRC];
  logic [Y_W-1:0]   y_arr   [N_SRC];
  logic [COL_W-1:0] col_arr [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign x_arr[i]   = src_x[i*X_W +: X_W];
    assign y_arr[i]   = src_y[i*Y_W +: Y_W];
    assign col_arr[i] = src_colour[i*COL_W +: COL_W];
  end

  // First requester strictly after ptr, wrapping; ptr = N_SRC-1 gives fixed priority.
  function automatic logic [IDX_W-1:0] pick(input logic [N_SRC-1:0] req,
                                            input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] w;
    logic             f;
    int               idx;
    w   = '0;
    f   = 1'b0;
    idx = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = (int'(ptr) + k) % N_SRC;
      if (!f && req[idx]) begin
        f = 1'b1;
        w = idx[IDX_W-1:0];
      end
    end
    return w;
  endfunction

  assign eligible = (|src_req) && ((FRAME_SYNC == 0) || pending_q);
  assign win      = pick(src_req, (MODE == 1) ? rr_ptr_q : IDX_LAST);
  assign g_end    = (src_valid[gnt_idx_q] && src_last[gnt_idx_q]) || !src_req[gnt_idx_q];
  // A dropped request aborts without plotting unless the pixel is also the last one.
  assign g_plot   = (state_q == GRANT) && src_valid[gnt_idx_q]
                    && (src_req[gnt_idx_q] || src_last[gnt_idx_q]);
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_idx_q <= '0;
      rr_ptr_q  <= IDX_LAST;
      gnt       <= '0;
      plot      <= 1'b0;
      x         <= '0;
      y         <= '0;
      colour    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && eligible) begin
        gnt_idx_q <= win;
        rr_ptr_q  <= win;
      end
      gnt    <= gnt_d;
      plot   <= plot_d;
      x      <= x_d;
      y      <= y_d;
      colour <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (eligible) state_d = GRANT;
      GRANT:   if (g_end) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d  = '0;
    plot_d = 1'b0;
    x_d    = x;
    y_d    = y;
    col_d  = colour;
    if (state_q == IDLE && eligible) gnt_d = N_SRC'(1) << win;
    if (state_q == GRANT) begin
      if (!g_end) gnt_d = gnt;
      if (g_plot) begin
        plot_d = 1'b1;
        x_d    = x_arr[gnt_idx_q];
        y_d    = y_arr[gnt_idx_q];
        col_d  = col_arr[gnt_idx_q];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= CNT_RELOAD;
      frame_tick <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      if (cnt_q == '0) begin
        cnt_q      <= CNT_RELOAD;
        frame_tick <= 1'b1;
      end else begin
        cnt_q      <= cnt_q - CNT_W'(1);
        frame_tick <= 1'b0;
      end
      if (FRAME_SYNC == 0)
        pending_q <= 1'b0;
      else if (frame_tick)
        pending_q <= 1'b1;
      else if (state_q == IDLE && !(|src_req))
        pending_q <= 1'b0;
    end
  end

endmodule
